conv3x3_seq: RTL and testbench

Parametrised sequencer for one 3x3 convolution layer over a 4-bank interleaved activation SRAM. It steps through every 2x2 output block and every input-channel group, producing activation, weight and bias read addresses plus accumulate-control strobes for the MAC datapath. It then issues the output write (bank enable, address, bytemask) after a fixed datapath latency. It generalises the fixed 6x6, 4-channel conv-3 controller to arbitrary map size, channel counts and pipeline depth, and adds a start/done handshake and stall support.

---
 rtl/conv3x3_seq.sv | 279 +++++++++++++++++++++++++++
 tb/tb_conv3x3_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_seq.sv
// Address/strobe sequencer for a 3x3 conv layer over a 4-bank interleaved activation SRAM.
// Walks oc/oy/ox/icg, issues reads, and emits the block write after a fixed datapath latency.
module conv3x3_seq #(
   parameter int unsigned CH_PER_ADDR = 4,
   parameter int unsigned IN_H        = 12,
   parameter int unsigned IN_W        = 12,
   parameter int unsigned IN_CH       = 4,
   parameter int unsigned OUT_CH      = 4,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WADDR_W     = 11,
   parameter int unsigned BADDR_W     = 7,
   parameter int unsigned WGT_BASE    = 0,
   parameter int unsigned BIAS_BASE   = 0,
   parameter int unsigned PIPE_LAT    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       stall,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_en,
   output logic [ADDR_W-1:0]          raddr_b0,
   output logic [ADDR_W-1:0]          raddr_b1,
   output logic [ADDR_W-1:0]          raddr_b2,
   output logic [ADDR_W-1:0]          raddr_b3,
   output logic [1:0]                 win_sel,
   output logic [WADDR_W-1:0]         raddr_weight,
   output logic [BADDR_W-1:0]         raddr_bias,
   output logic                       acc_clr,
   output logic                       acc_last,
   output logic [3:0]                 wen,
   output logic [ADDR_W-1:0]          waddr,
   output logic [4*CH_PER_ADDR-1:0]   bytemask
);

   localparam int unsigned ICG   = IN_CH / CH_PER_ADDR;
   localparam int unsigned OB_H  = IN_H / 2 - 1;
   localparam int unsigned OB_W  = IN_W / 2 - 1;
   localparam int unsigned OR_H  = (OB_H + 1) / 2;
   localparam int unsigned OR_W  = (OB_W + 1) / 2;
   localparam int unsigned H4    = IN_H / 4;
   localparam int unsigned W4    = IN_W / 4;
   localparam int unsigned PLANE = H4 * W4;

   localparam int unsigned ICG_W = (ICG > 1)         ? $clog2(ICG)         : 1;
   localparam int unsigned OX_W  = (OB_W > 1)        ? $clog2(OB_W)        : 1;
   localparam int unsigned OY_W  = (OB_H > 1)        ? $clog2(OB_H)        : 1;
   localparam int unsigned OC_W  = (OUT_CH > 1)      ? $clog2(OUT_CH)      : 1;
   localparam int unsigned JW    = (CH_PER_ADDR > 1) ? $clog2(CH_PER_ADDR) : 1;
   localparam int unsigned MW    = 4 * CH_PER_ADDR;

   localparam logic [ICG_W-1:0] ICG_MAX = ICG_W'(ICG - 1);
   localparam logic [OX_W-1:0]  OX_MAX  = OX_W'(OB_W - 1);
   localparam logic [OY_W-1:0]  OY_MAX  = OY_W'(OB_H - 1);
   localparam logic [OC_W-1:0]  OC_MAX  = OC_W'(OUT_CH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [ICG_W-1:0]    icg_q, icg_d;
   logic [OX_W-1:0]     ox_q, ox_d;
   logic [OY_W-1:0]     oy_q, oy_d;
   logic [OC_W-1:0]     oc_q, oc_d;
   logic                issue;
   logic                pipe_empty;

   logic [ADDR_W-1:0]   rb_d [4];
   logic [WADDR_W-1:0]  wt_d;
   logic [BADDR_W-1:0]  bs_d;
   logic [ADDR_W-1:0]   wa_d;
   logic [JW-1:0]       j_d;

   logic                busy_q, done_q, rd_en_q;
   logic [ADDR_W-1:0]   rb_q [4];
   logic [WADDR_W-1:0]  wt_q;
   logic [BADDR_W-1:0]  bs_q;

   logic                a_valid_q, a_clr_q, a_last_q;
   logic [1:0]          a_win_q;
   logic [ADDR_W-1:0]   a_waddr_q;
   logic [JW-1:0]       a_j_q;

   logic [1:0]          win_q;
   logic                acc_clr_q, acc_last_q;

   logic [PIPE_LAT-1:0] dl_v_q;
   logic [1:0]          dl_bank_q [PIPE_LAT];
   logic [ADDR_W-1:0]   dl_addr_q [PIPE_LAT];
   logic [JW-1:0]       dl_j_q    [PIPE_LAT];

   logic [3:0]          wen_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [MW-1:0]       mask_q;

   // Bank (py,px) reads the nearest 2x2 word whose parity matches, stepping +1 when it does not.
   function automatic logic [ADDR_W-1:0] act_addr(input int unsigned icg, input int unsigned oy,
                                                  input int unsigned ox, input int unsigned py,
                                                  input int unsigned px);
      int unsigned by, bx;
      by = ((oy % 2) == py) ? oy : oy + 1;
      bx = ((ox % 2) == px) ? ox : ox + 1;
      return ADDR_W'(icg * PLANE + (by >> 1) * W4 + (bx >> 1));
   endfunction

   function automatic logic [MW-1:0] lane_mask(input logic [JW-1:0] j);
      logic [MW-1:0] m;
      m = '1;
      for (int unsigned k = 0; k < CH_PER_ADDR; k++) begin
         if (k == CH_PER_ADDR - 1 - 32'(j)) m[k*4 +: 4] = '0;
      end
      return m;
   endfunction

   assign pipe_empty = !a_valid_q && (dl_v_q == '0);

   always_comb begin
      state_d = state_q;
      icg_d   = icg_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      oc_d    = oc_q;
      issue   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               icg_d   = '0;
               ox_d    = '0;
               oy_d    = '0;
               oc_d    = '0;
            end
         end
         S_RUN: begin
            if (!stall) begin
               issue = 1'b1;
               if (icg_q != ICG_MAX) begin
                  icg_d = icg_q + ICG_W'(1);
               end else begin
                  icg_d = '0;
                  if (ox_q != OX_MAX) begin
                     ox_d = ox_q + OX_W'(1);
                  end else begin
                     ox_d = '0;
                     if (oy_q != OY_MAX) begin
                        oy_d = oy_q + OY_W'(1);
                     end else begin
                        oy_d = '0;
                        if (oc_q != OC_MAX) begin
                           oc_d = oc_q + OC_W'(1);
                        end else begin
                           oc_d    = '0;
                           state_d = S_DRAIN;
                        end
                     end
                  end
               end
            end
         end
         S_DRAIN: begin
            if (pipe_empty) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rb_d[0] = act_addr(32'(icg_q), 32'(oy_q), 32'(ox_q), 0, 0);
      rb_d[1] = act_addr(32'(icg_q), 32'(oy_q), 32'(ox_q), 0, 1);
      rb_d[2] = act_addr(32'(icg_q), 32'(oy_q), 32'(ox_q), 1, 0);
      rb_d[3] = act_addr(32'(icg_q), 32'(oy_q), 32'(ox_q), 1, 1);
      wt_d    = WADDR_W'(WGT_BASE + 32'(oc_q) * ICG + 32'(icg_q));
      bs_d    = BADDR_W'(BIAS_BASE + 32'(oc_q));
      wa_d    = ADDR_W'((32'(oc_q) / CH_PER_ADDR) * OR_H * OR_W
                        + (32'(oy_q) >> 1) * OR_W + (32'(ox_q) >> 1));
      j_d     = JW'(32'(oc_q) % CH_PER_ADDR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         icg_q      <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         oc_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         for (int unsigned b = 0; b < 4; b++) rb_q[b] <= '0;
         wt_q       <= WADDR_W'(WGT_BASE);
         bs_q       <= BADDR_W'(BIAS_BASE);
         a_valid_q  <= 1'b0;
         a_clr_q    <= 1'b0;
         a_last_q   <= 1'b0;
         a_win_q    <= '0;
         a_waddr_q  <= '0;
         a_j_q      <= '0;
         win_q      <= '0;
         acc_clr_q  <= 1'b0;
         acc_last_q <= 1'b0;
         dl_v_q     <= '0;
         for (int unsigned k = 0; k < PIPE_LAT; k++) begin
            dl_bank_q[k] <= '0;
            dl_addr_q[k] <= '0;
            dl_j_q[k]    <= '0;
         end
         wen_q      <= '1;
         waddr_q    <= '0;
         mask_q     <= '1;
      end else begin
         state_q <= state_d;
         icg_q   <= icg_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         oc_q    <= oc_d;
         busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
         if (stall) begin
            // Every pipeline stage holds; only the strobes are forced inactive.
            rd_en_q    <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_last_q <= 1'b0;
            wen_q      <= '1;
         end else begin
            rd_en_q   <= issue;
            a_valid_q <= issue;
            if (issue) begin
               for (int unsigned b = 0; b < 4; b++) rb_q[b] <= rb_d[b];
               wt_q      <= wt_d;
               bs_q      <= bs_d;
               a_clr_q   <= (icg_q == '0);
               a_last_q  <= (icg_q == ICG_MAX);
               a_win_q   <= {oy_q[0], ox_q[0]};
               a_waddr_q <= wa_d;
               a_j_q     <= j_d;
            end
            acc_clr_q  <= a_valid_q && a_clr_q;
            acc_last_q <= a_valid_q && a_last_q;
            if (a_valid_q) win_q <= a_win_q;
            dl_v_q[0]    <= a_valid_q && a_last_q;
            dl_bank_q[0] <= a_win_q;
            dl_addr_q[0] <= a_waddr_q;
            dl_j_q[0]    <= a_j_q;
            for (int unsigned k = 1; k < PIPE_LAT; k++) begin
               dl_v_q[k]    <= dl_v_q[k-1];
               dl_bank_q[k] <= dl_bank_q[k-1];
               dl_addr_q[k] <= dl_addr_q[k-1];
               dl_j_q[k]    <= dl_j_q[k-1];
            end
            if (dl_v_q[PIPE_LAT-1]) begin
               wen_q   <= ~(4'b0001 << dl_bank_q[PIPE_LAT-1]);
               waddr_q <= dl_addr_q[PIPE_LAT-1];
               mask_q  <= lane_mask(dl_j_q[PIPE_LAT-1]);
            end else begin
               wen_q   <= '1;
            end
         end
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign rd_en        = rd_en_q;
   assign raddr_b0     = rb_q[0];
   assign raddr_b1     = rb_q[1];
   assign raddr_b2     = rb_q[2];
   assign raddr_b3     = rb_q[3];
   assign raddr_weight = wt_q;
   assign raddr_bias   = bs_q;
   assign win_sel      = win_q;
   assign acc_clr      = acc_clr_q;
   assign acc_last     = acc_last_q;
   assign wen          = wen_q;
   assign waddr        = waddr_q;
   assign bytemask     = mask_q;

endmodule

// File: tb/tb_conv3x3_seq.sv
// Directed bench for conv3x3_seq: default 12x12x4->4 layer plus an 8-input-channel instance.
module tb_conv3x3_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, stall, start2, stall2;

   logic        busy, done, rd_en, acc_clr, acc_last;
   logic [9:0]  raddr_b0, raddr_b1, raddr_b2, raddr_b3, waddr;
   logic [1:0]  win_sel;
   logic [10:0] raddr_weight;
   logic [6:0]  raddr_bias;
   logic [3:0]  wen;
   logic [15:0] bytemask;

   logic        busy2, done2, rd_en2, acc_clr2, acc_last2;
   logic [9:0]  r2_b0, r2_b1, r2_b2, r2_b3, waddr2;
   logic [1:0]  win_sel2;
   logic [10:0] r2_w;
   logic [6:0]  r2_bi;
   logic [3:0]  wen2;
   logic [15:0] bytemask2;

   conv3x3_seq u_dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .busy(busy), .done(done), .rd_en(rd_en),
      .raddr_b0(raddr_b0), .raddr_b1(raddr_b1), .raddr_b2(raddr_b2), .raddr_b3(raddr_b3),
      .win_sel(win_sel), .raddr_weight(raddr_weight), .raddr_bias(raddr_bias),
      .acc_clr(acc_clr), .acc_last(acc_last),
      .wen(wen), .waddr(waddr), .bytemask(bytemask)
   );

   conv3x3_seq #(.IN_CH(8)) u_icg2 (
      .clk(clk), .rst(rst), .start(start2), .stall(stall2),
      .busy(busy2), .done(done2), .rd_en(rd_en2),
      .raddr_b0(r2_b0), .raddr_b1(r2_b1), .raddr_b2(r2_b2), .raddr_b3(r2_b3),
      .win_sel(win_sel2), .raddr_weight(r2_w), .raddr_bias(r2_bi),
      .acc_clr(acc_clr2), .acc_last(acc_last2),
      .wen(wen2), .waddr(waddr2), .bytemask(bytemask2)
   );

   int total, bad;

   typedef struct {
      int oc; int oy; int ox;
      int b0; int b1; int b2; int b3;
      int win; int wen; int wa; int mask;
   } vec_t;
   vec_t tbl [8];

   logic [9:0]  lg_b0 [128], lg_b1 [128], lg_b2 [128], lg_b3 [128];
   logic [10:0] lg_w  [128];
   logic [6:0]  lg_bi [128];
   int          lg_rc [128];
   logic [1:0]  lg_win [128];
   logic        lg_clr [128];
   int          lg_fc [128];
   logic [3:0]  lg_wen [128];
   logic [9:0]  lg_wa [128];
   logic [15:0] lg_m [128];
   int          lg_wc [128];
   int n_rd, n_fl, n_wr, n_done, multi_low, clr_ne_last, busy0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Closed-form read address for step k of the default layer.
   function automatic int mdl_addr(input int k, input int bank);
      int oy, ox, r, c;
      oy = (k / 5) % 5;
      ox = k % 5;
      r  = (bank >= 2) ? oy / 2 : (oy + 1) / 2;
      c  = (bank % 2 == 1) ? ox / 2 : (ox + 1) / 2;
      return r * 3 + c;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_rd_en"}, 32'(rd_en), 0);
      chk({tag, "_acc"},   32'({acc_clr, acc_last}), 0);
      chk({tag, "_raddr"}, 32'({raddr_b0, raddr_b1, raddr_b2}) | 32'(raddr_b3), 0);
      chk({tag, "_wgt"},   32'(raddr_weight), 0);
      chk({tag, "_bias"},  32'(raddr_bias), 0);
      chk({tag, "_win"},   32'(win_sel), 0);
      chk({tag, "_wen"},   32'(wen), 32'hF);
      chk({tag, "_waddr"}, 32'(waddr), 0);
      chk({tag, "_mask"},  32'(bytemask), 32'hFFFF);
   endtask

   task automatic run_layer(input int stall_at, input int stall_len, input int restart_at);
      bit fin;
      fin = 0;
      n_rd = 0; n_fl = 0; n_wr = 0; n_done = 0; multi_low = 0; clr_ne_last = 0; busy0 = 0;
      for (int c = 0; c < 1000 && !fin; c++) begin
         start = (c == 0) || (c == restart_at);
         stall = (c >= stall_at) && (c < stall_at + stall_len);
         tick();
         if (c == 0) busy0 = int'(busy);
         if (stall) begin
            chk("stall_rd_en", 32'(rd_en), 0);
            chk("stall_wen", 32'(wen), 32'hF);
            chk("stall_acc", 32'({acc_clr, acc_last}), 0);
            chk("stall_b0_hold", 32'(raddr_b0), mdl_addr(n_rd - 1, 0));
            chk("stall_b3_hold", 32'(raddr_b3), mdl_addr(n_rd - 1, 3));
            chk("stall_wgt_hold", 32'(raddr_weight), (n_rd - 1) / 25);
         end
         if (rd_en) begin
            if (n_rd < 128) begin
               lg_b0[n_rd] = raddr_b0; lg_b1[n_rd] = raddr_b1;
               lg_b2[n_rd] = raddr_b2; lg_b3[n_rd] = raddr_b3;
               lg_w[n_rd] = raddr_weight; lg_bi[n_rd] = raddr_bias; lg_rc[n_rd] = c;
            end
            n_rd++;
         end
         if (acc_clr !== acc_last) clr_ne_last++;
         if (acc_last) begin
            if (n_fl < 128) begin
               lg_win[n_fl] = win_sel; lg_clr[n_fl] = acc_clr; lg_fc[n_fl] = c;
            end
            n_fl++;
         end
         if (wen != 4'hF) begin
            if ($countones(~wen) != 1) multi_low++;
            if (n_wr < 128) begin
               lg_wen[n_wr] = wen; lg_wa[n_wr] = waddr; lg_m[n_wr] = bytemask; lg_wc[n_wr] = c;
            end
            n_wr++;
         end
         if (done) begin
            n_done++;
            fin = 1;
         end
      end
      start = 1'b0;
      stall = 1'b0;
      if (!fin) chk("layer_timeout", 0, 1);
      tick();
      chk("done_single_cycle", 32'(done), 0);
   endtask

   initial begin
      int k, cnt, w2;
      bit seen;
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0;

      tbl[0] = '{0, 0, 0,  0, 0, 0, 0,  0, 'hE, 0, 'h0FFF};
      tbl[1] = '{2, 1, 2,  4, 4, 1, 1,  2, 'hB, 1, 'hFF0F};
      tbl[2] = '{0, 0, 1,  1, 0, 1, 0,  1, 'hD, 0, 'h0FFF};
      tbl[3] = '{1, 3, 3,  8, 7, 5, 4,  3, 'h7, 4, 'hF0FF};
      tbl[4] = '{3, 4, 4,  8, 8, 8, 8,  0, 'hE, 8, 'hFFF0};
      tbl[5] = '{3, 4, 1,  7, 6, 7, 6,  1, 'hD, 6, 'hFFF0};
      tbl[6] = '{1, 1, 0,  3, 3, 0, 0,  2, 'hB, 0, 'hF0FF};
      tbl[7] = '{2, 2, 3,  5, 4, 5, 4,  1, 'hD, 4, 'hFF0F};

      tick(); tick();
      check_reset("init");
      rst = 1'b0;
      tick();

      // Plain layer, logged and compared against the block table.
      run_layer(100000, 0, -1);
      chk("busy_after_start", busy0, 1);
      chk("reads", n_rd, 100);
      chk("acc_last_count", n_fl, 100);
      chk("writes", n_wr, 100);
      chk("done_pulses", n_done, 1);
      chk("wen_multi_low", multi_low, 0);
      chk("icg1_clr_eq_last", clr_ne_last, 0);
      chk("first_raddr", 32'({lg_b0[0], lg_b1[0], lg_b2[0]}) | 32'(lg_b3[0]), 0);
      chk("first_wgt", 32'(lg_w[0]), 0);
      chk("first_bias", 32'(lg_bi[0]), 0);
      chk("first_clr", 32'(lg_clr[0]), 1);
      for (int i = 0; i < 8; i++) begin
         k = tbl[i].oc * 25 + tbl[i].oy * 5 + tbl[i].ox;
         chk("tbl_b0", 32'(lg_b0[k]), tbl[i].b0);
         chk("tbl_b1", 32'(lg_b1[k]), tbl[i].b1);
         chk("tbl_b2", 32'(lg_b2[k]), tbl[i].b2);
         chk("tbl_b3", 32'(lg_b3[k]), tbl[i].b3);
         chk("tbl_wgt", 32'(lg_w[k]), tbl[i].oc);
         chk("tbl_bias", 32'(lg_bi[k]), tbl[i].oc);
         chk("tbl_win", 32'(lg_win[k]), tbl[i].win);
         chk("tbl_wen", 32'(lg_wen[k]), tbl[i].wen);
         chk("tbl_waddr", 32'(lg_wa[k]), tbl[i].wa);
         chk("tbl_mask", 32'(lg_m[k]), tbl[i].mask);
         chk("tbl_rd_to_acc", lg_fc[k] - lg_rc[k], 1);
         chk("tbl_acc_to_wr", lg_wc[k] - lg_fc[k], 3);
      end

      // Five-cycle stall in mid-RUN, started in the cycle right after the previous done.
      run_layer(30, 5, -1);
      chk("stall_reads", n_rd, 100);
      chk("stall_writes", n_wr, 100);
      chk("stall_done", n_done, 1);
      chk("stall_last_waddr", 32'(lg_wa[99]), 8);

      // start pulsed while running must be ignored.
      run_layer(100000, 0, 20);
      chk("restart_reads", n_rd, 100);
      chk("restart_writes", n_wr, 100);
      chk("restart_done", n_done, 1);

      // Synchronous reset after the 40th read.
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      seen = 0;
      for (int c = 0; c < 500 && !seen; c++) begin
         tick();
         if (rd_en) cnt++;
         if (cnt == 40) seen = 1;
      end
      if (!seen) chk("midrst_timeout", 0, 1);
      rst = 1'b1;
      tick();
      check_reset("midrst");
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (rd_en || done || busy || wen != 4'hF) cnt++;
      end
      chk("midrst_quiet", cnt, 0);

      // Two input-channel groups per block.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (rd_en2) seen = 1;
      end
      if (!seen) chk("icg2_timeout", 0, 1);
      chk("icg2_s0_wgt", 32'(r2_w), 0);
      chk("icg2_s0_raddr", 32'({r2_b0, r2_b1, r2_b2}) | 32'(r2_b3), 0);
      cnt = 1; w2 = 0;
      tick();
      if (rd_en2) cnt++;
      chk("icg2_s1_clr", 32'(acc_clr2), 1);
      chk("icg2_s1_last", 32'(acc_last2), 0);
      chk("icg2_s1_wgt", 32'(r2_w), 1);
      chk("icg2_s1_b0", 32'(r2_b0), 9);
      chk("icg2_s1_b1", 32'(r2_b1), 9);
      chk("icg2_s1_b2", 32'(r2_b2), 9);
      chk("icg2_s1_b3", 32'(r2_b3), 9);
      tick();
      if (rd_en2) cnt++;
      chk("icg2_s2_clr", 32'(acc_clr2), 0);
      chk("icg2_s2_last", 32'(acc_last2), 1);
      seen = 0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         tick();
         if (rd_en2) cnt++;
         if (wen2 != 4'hF) w2++;
         if (done2) seen = 1;
      end
      if (!seen) chk("icg2_done_timeout", 0, 1);
      chk("icg2_reads", cnt, 200);
      chk("icg2_writes", w2, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
